pixel_shifter: RTL and testbench

PIXEL_SHIFTER -- requirements
Module: pixel_shifter

---
 rtl/pixel_shifter_if.sv | 39 +++
 rtl/pixel_shifter.sv | 108 ++++++++++
 tb/tb_pixel_shifter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_shifter_if.sv
// Bundles the pixel shifter's data and status signals between producer and shifter.
// Latency: none, wires only.
// Backpressure: carries req (load will not be lost) and the sticky ovf flag.
//
// Ports (master = producer side, slave = shifter side):
//   ce        clock enable qualifying every synchronous action
//   ser_in    fill bit entering the vacated end of the shift register
//   p         parallel load data, WIDTH bits
//   load_n    parallel-load request, active-low
//   q         serial pixel out
//   empty     no loaded bits remain
//   bits_left loaded bits not yet shifted out
//   req       a load now would be accepted without loss
//   ovf       sticky, a load was lost
interface pixel_shifter_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic             ce;
    logic             ser_in;
    logic [WIDTH-1:0] p;
    logic             load_n;
    logic             q;
    logic             empty;
    logic [CW-1:0]    bits_left;
    logic             req;
    logic             ovf;

    modport master (
        output ce, ser_in, p, load_n,
        input  q, empty, bits_left, req, ovf
    );

    modport slave (
        input  ce, ser_in, p, load_n,
        output q, empty, bits_left, req, ovf
    );
endinterface

// File: rtl/pixel_shifter.sv
// Parallel-in, serial-out pixel shift register with loaded-bit counter and overflow flag.
// Latency: first bit of a load on q one ce edge after the load (one more with the holding register).
// Backpressure: req advertises a lossless load; a lost load sets sticky ovf, cleared only by clr_n.
//
// Ports: clk (rising edge), clr_n (async active-low reset), bus (pixel_shifter_if.slave).
// Parameters: WIDTH (2..32) register length, LSB_FIRST (0: q from MSB, 1: q from LSB).
// Optional feature: define PIXEL_SHIFTER_DBUF_EN to add a one-character holding register
// that refills the shifter gaplessly when it runs down to its last bit.
module pixel_shifter #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic            clk,
    input  logic            clr_n,
    pixel_shifter_if.slave  bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;

    logic [WIDTH-1:0] w_shifted;
    logic [CW-1:0]    w_cnt_dec;
    logic             w_low;

    // Shift moves toward q; the fill bit enters the far end.
    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign w_shifted = {bus.ser_in, r_sh[WIDTH-1:1]};
            assign bus.q     = r_sh[0];
        end else begin : g_msb
            assign w_shifted = {r_sh[WIDTH-2:0], bus.ser_in};
            assign bus.q     = r_sh[WIDTH-1];
        end
    endgenerate

    // Counter saturates at zero; shifting carries on while empty.
    assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
    // At most the last bit is still pending.
    assign w_low     = (r_cnt <= CW'(1));

    assign bus.empty     = (r_cnt == '0);
    assign bus.bits_left = r_cnt;
    assign bus.ovf       = r_ovf;

`ifdef PIXEL_SHIFTER_DBUF_EN
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_vld;
    logic             w_xfer;

    // Refill from the holding register on the cycle the last bit is on q,
    // so the next character follows with no gap.
    assign w_xfer  = r_hold_vld & w_low;
    assign bus.req = ~r_hold_vld;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sh       <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
        end else if (bus.ce) begin
            if (w_xfer) begin
                r_sh  <= r_hold;
                r_cnt <= FULL;
            end else begin
                r_sh  <= w_shifted;
                r_cnt <= w_cnt_dec;
            end
            if (!bus.load_n) begin
                r_hold     <= bus.p;
                r_hold_vld <= 1'b1;
                // Overwriting a held character that is not leaving this cycle loses it.
                if (r_hold_vld && !w_xfer) begin
                    r_ovf <= 1'b1;
                end
            end else if (w_xfer) begin
                r_hold_vld <= 1'b0;
            end
        end
    end
`else
    assign bus.req = w_low;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (bus.ce) begin
            if (!bus.load_n) begin
                r_sh  <= bus.p;
                r_cnt <= FULL;
                // Two or more unsent bits are discarded by this load.
                if (!w_low) begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_sh  <= w_shifted;
                r_cnt <= w_cnt_dec;
            end
        end
    end
`endif
endmodule

// File: tb/tb_pixel_shifter.sv
// Scoreboard bench for pixel_shifter: one MSB-first and one LSB-first instance, WIDTH=8.
// Expected outputs are queued as each cycle's stimulus is driven and popped after the edge.
// Build with or without PIXEL_SHIFTER_DBUF_EN; expectations follow the same macro.
module tb_pixel_shifter;
`ifdef PIXEL_SHIFTER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    pixel_shifter_if #(.WIDTH(8)) if_a ();
    pixel_shifter_if #(.WIDTH(8)) if_b ();

    pixel_shifter #(.WIDTH(8), .LSB_FIRST(0)) u_msb (.clk(clk), .clr_n(clr_n), .bus(if_a));
    pixel_shifter #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (.clk(clk), .clr_n(clr_n), .bus(if_b));

    typedef struct {
        string      tag;
        logic       q;
        logic       empty;
        logic [3:0] bl;
        logic       req;
        logic       ovf;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   n_run  = 0;
    int   n_fail = 0;
    logic ovf_e  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // i-th bit to leave q for character v; fill once the character is used up.
    function automatic logic nth(input logic [7:0] v, input int i, input bit lsb, input logic fill);
        if (i >= 8) return fill;
        return lsb ? v[3'(i)] : v[3'(7 - i)];
    endfunction

    function automatic logic rq(input int bl, input bit hv);
        return DBUF ? !hv : (bl <= 1);
    endfunction

    function automatic exp_t mk(input string tag, input logic q, input int bl, input logic req);
        exp_t e;
        e.tag   = tag;
        e.q     = q;
        e.bl    = 4'(bl);
        e.empty = (bl == 0);
        e.req   = req;
        e.ovf   = ovf_e;
        return e;
    endfunction

    task automatic cmp(input exp_t g, input logic q, input logic empty, input logic [3:0] bl,
                       input logic req, input logic ovf);
        check({g.tag, ".q"},     {31'd0, q},     {31'd0, g.q});
        check({g.tag, ".empty"}, {31'd0, empty}, {31'd0, g.empty});
        check({g.tag, ".bl"},    {28'd0, bl},    {28'd0, g.bl});
        check({g.tag, ".req"},   {31'd0, req},   {31'd0, g.req});
        check({g.tag, ".ovf"},   {31'd0, ovf},   {31'd0, g.ovf});
    endtask

    // Drive one cycle on the selected instance (other one idles with ce=0), queue its
    // expected post-edge outputs, then compare whatever the scoreboard holds.
    task automatic step(input bit sel, input bit ce, input bit ld_n, input logic [7:0] pv,
                        input logic ser, input exp_t e);
        exp_t g;
        if (sel) begin
            if_b.ce = ce; if_b.load_n = ld_n; if_b.p = pv; if_b.ser_in = ser;
            if_a.ce = 1'b0; if_a.load_n = 1'b1;
            sb_b.push_back(e);
        end else begin
            if_a.ce = ce; if_a.load_n = ld_n; if_a.p = pv; if_a.ser_in = ser;
            if_b.ce = 1'b0; if_b.load_n = 1'b1;
            sb_a.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb_a.size() > 0) begin
            g = sb_a.pop_front();
            cmp(g, if_a.q, if_a.empty, if_a.bits_left, if_a.req, if_a.ovf);
        end
        while (sb_b.size() > 0) begin
            g = sb_b.pop_front();
            cmp(g, if_b.q, if_b.empty, if_b.bits_left, if_b.req, if_b.ovf);
        end
    endtask

    // Load a character into an empty, zero-filled shifter until its first bit is on q.
    task automatic load_char(input bit sel, input logic [7:0] v, input logic ser, input string tag);
`ifdef PIXEL_SHIFTER_DBUF_EN
        step(sel, 1'b1, 1'b0, v, ser, mk({tag, "/ld"}, 1'b0, 0, rq(0, 1'b1)));
        step(sel, 1'b1, 1'b1, 8'h00, ser, mk({tag, "/xf"}, nth(v, 0, sel, ser), 8, rq(8, 1'b0)));
`else
        step(sel, 1'b1, 1'b0, v, ser, mk({tag, "/ld"}, nth(v, 0, sel, ser), 8, rq(8, 1'b0)));
`endif
    endtask

    task automatic drain(input bit sel, input logic [7:0] v, input logic ser, input int n,
                         input string tag);
        for (int k = 1; k <= n; k++) begin
            step(sel, 1'b1, 1'b1, 8'h00, ser,
                 mk($sformatf("%s/s%0d", tag, k), nth(v, k, sel, ser), (k >= 8) ? 0 : 8 - k,
                    rq((k >= 8) ? 0 : 8 - k, 1'b0)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  en;
        clr_n = 1'b0;
        if_a.ce = 1'b0; if_a.load_n = 1'b1; if_a.p = 8'h00; if_a.ser_in = 1'b0;
        if_b.ce = 1'b0; if_b.load_n = 1'b1; if_b.p = 8'h00; if_b.ser_in = 1'b0;
        #12;
        check("rst_a.q",     {31'd0, if_a.q},         32'd0);
        check("rst_a.empty", {31'd0, if_a.empty},     32'd1);
        check("rst_a.bl",    {28'd0, if_a.bits_left}, 32'd0);
        check("rst_a.req",   {31'd0, if_a.req},       32'd1);
        check("rst_a.ovf",   {31'd0, if_a.ovf},       32'd0);
        check("rst_b.q",     {31'd0, if_b.q},         32'd0);
        check("rst_b.req",   {31'd0, if_b.req},       32'd1);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        // LSB-first: 8'h01 with ser_in=1 -> 1, seven 0s, then 1s.
        load_char(1'b1, 8'h01, 1'b1, "lsb");
        drain(1'b1, 8'h01, 1'b1, 10, "lsb");

        // MSB-first: 8'hA5 -> 1,0,1,0,0,1,0,1 then empty with q=0.
        load_char(1'b0, 8'hA5, 1'b0, "a5");
        drain(1'b0, 8'hA5, 1'b0, 9, "a5");

        // ce toggling on 8'hF0; load_n asserted during ce=0 cycles must be ignored.
        load_char(1'b0, 8'hF0, 1'b0, "ce");
        k = 0;
        for (int c = 0; c < 16; c++) begin
            en = (c % 2 == 0);
            if (en) k++;
            step(1'b0, en, en, 8'hFF, 1'b0,
                 mk($sformatf("ce/c%0d", c), nth(8'hF0, k, 1'b0, 1'b0), (k >= 8) ? 0 : 8 - k,
                    rq((k >= 8) ? 0 : 8 - k, 1'b0)));
        end

`ifdef PIXEL_SHIFTER_DBUF_EN
        // Gapless back-to-back: FF then 00 queued while FF shifts.
        step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, mk("gap/l1", 1'b0, 0, rq(0, 1'b1)));
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, mk("gap/xf1", 1'b1, 8, rq(8, 1'b0)));
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, mk("gap/l2", 1'b1, 7, rq(7, 1'b1)));
        for (int j = 2; j <= 7; j++) begin
            step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0,
                 mk($sformatf("gap/s%0d", j), 1'b1, 8 - j, rq(8 - j, 1'b1)));
        end
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, mk("gap/xf2", 1'b0, 8, rq(8, 1'b0)));
        drain(1'b0, 8'h00, 1'b0, 9, "gap/z");

        // Three consecutive loads: C3 shifts, 18 is lost, 5A follows gaplessly.
        step(1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, mk("tri/l1", 1'b0, 0, rq(0, 1'b1)));
        step(1'b0, 1'b1, 1'b0, 8'h18, 1'b0,
             mk("tri/l2", nth(8'hC3, 0, 1'b0, 1'b0), 8, rq(8, 1'b1)));
        ovf_e = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0,
             mk("tri/l3", nth(8'hC3, 1, 1'b0, 1'b0), 7, rq(7, 1'b1)));
        for (int j = 2; j <= 7; j++) begin
            step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0,
                 mk($sformatf("tri/s%0d", j), nth(8'hC3, j, 1'b0, 1'b0), 8 - j, rq(8 - j, 1'b1)));
        end
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0,
             mk("tri/xf", nth(8'h5A, 0, 1'b0, 1'b0), 8, rq(8, 1'b0)));
        drain(1'b0, 8'h5A, 1'b0, 9, "tri/c");
`else
        // Two loads on consecutive edges: first is lost, second shifts.
        step(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0,
             mk("two/l1", nth(8'hAA, 0, 1'b0, 1'b0), 8, rq(8, 1'b0)));
        ovf_e = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'h3C, 1'b0,
             mk("two/l2", nth(8'h3C, 0, 1'b0, 1'b0), 8, rq(8, 1'b0)));
        drain(1'b0, 8'h3C, 1'b0, 9, "two/c");
`endif

        // Asynchronous reset mid-character, between edges.
        load_char(1'b0, 8'hA5, 1'b0, "ar");
        drain(1'b0, 8'hA5, 1'b0, 3, "ar");
        #2;
        clr_n = 1'b0;
        #1;
        check("ar.q",     {31'd0, if_a.q},         32'd0);
        check("ar.empty", {31'd0, if_a.empty},     32'd1);
        check("ar.bl",    {28'd0, if_a.bits_left}, 32'd0);
        check("ar.req",   {31'd0, if_a.req},       32'd1);
        check("ar.ovf",   {31'd0, if_a.ovf},       32'd0);
        ovf_e = 1'b0;
        #1;
        clr_n = 1'b1;

        // First ce cycle after reset is ordinary operation.
        step(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, mk("post/idle", 1'b0, 0, rq(0, 1'b0)));
        load_char(1'b0, 8'h3C, 1'b0, "post");
        drain(1'b0, 8'h3C, 1'b0, 3, "post");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
